// File: rtl/gfg_fb_pkg.sv
// gfg_fb_pkg: shared encodings and helpers for the gfg frame-buffer swap controller
//   role_e  : per-buffer ownership role stored in the role table
//   state_e : rasterizer handshake FSM states
//   idx_w() : buffer index width, never narrower than one bit
package gfg_fb_pkg;
  typedef enum logic [1:0] {
    ROLE_FREE    = 2'd0,
    ROLE_DISPLAY = 2'd1,
    ROLE_RENDER  = 2'd2,
    ROLE_READY   = 2'd3
  } role_e;
  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_RENDER    = 2'd1,
    S_WAIT_FREE = 2'd2
  } state_e;
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/gfg_free_buffer_picker.sv
// gfg_free_buffer_picker: combinational lowest-index FREE buffer finder
//   i_roles : role table, one 2-bit role per buffer
//   o_found : at least one buffer is FREE
//   o_idx   : lowest FREE buffer index (0 when none)
module gfg_free_buffer_picker
  import gfg_fb_pkg::*;
#(
  parameter int N     = 3,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0][1:0] i_roles,
  output logic              o_found,
  output logic [IDX_W-1:0]  o_idx
);
  // scanning downward lets the lowest match overwrite higher ones
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_roles[i] == ROLE_FREE) begin
        o_found = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/gfg_frame_buffer_swap_ctrl.sv
// gfg_frame_buffer_swap_ctrl: N-buffer ownership/swap controller between rasterizer and VGA read side
//   i_clk, i_arst_n        : clock, asynchronous active-low reset
//   i_vblank_start         : vblank pulse, promotes a READY frame when VSYNC_LOCKED
//   i_raster_start_req     : level request for a render target, held until granted
//   i_raster_done          : pulse, current render buffer complete
//   o_raster_grant/target  : grant pulse and buffer index the rasterizer writes
//   o_raster_in_progress   : FSM is in S_RENDER
//   o_display_source       : buffer index the VGA side reads; o_new_frame pulses on change
//   o_ready_pending        : a READY buffer exists
//   o_dropped_frames       : saturating count of overwritten READY frames
//   o_protocol_err         : sticky, done seen outside S_RENDER
module gfg_frame_buffer_swap_ctrl
  import gfg_fb_pkg::*;
#(
  parameter  int NUM_BUFFERS  = 3,
  parameter  int VSYNC_LOCKED = 1,
  parameter  int DROP_CNT_W   = 16,
  localparam int IDX_W        = idx_w(NUM_BUFFERS)
) (
  input  logic                  i_clk,
  input  logic                  i_arst_n,
  input  logic                  i_vblank_start,
  input  logic                  i_raster_start_req,
  input  logic                  i_raster_done,
  output logic                  o_raster_grant,
  output logic [IDX_W-1:0]      o_raster_target,
  output logic                  o_raster_in_progress,
  output logic [IDX_W-1:0]      o_display_source,
  output logic                  o_new_frame,
  output logic                  o_ready_pending,
  output logic [DROP_CNT_W-1:0] o_dropped_frames,
  output logic                  o_protocol_err
);
  logic [NUM_BUFFERS-1:0][1:0] r_roles, w_roles_upd, w_roles_nxt;
  state_e                      r_state, w_state_nxt;
  logic [IDX_W-1:0]            r_target, r_disp, w_disp_nxt, w_ready_idx, w_free_idx;
  logic                        r_grant, r_new_frame, r_err;
  logic                        w_ready_found, w_free_found, w_done, w_drop, w_grant;
  logic                        w_promote_done, w_promote_ready, w_new_frame;
  logic [DROP_CNT_W-1:0]       r_drop_cnt;

  always_comb begin
    w_ready_found = 1'b0;
    w_ready_idx   = '0;
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      if (r_roles[i] == ROLE_READY) begin
        w_ready_found = 1'b1;
        w_ready_idx   = IDX_W'(i);
      end
    end
  end

  // display-side update first; the grant below sees the buffers it frees
  always_comb begin
    w_done          = i_raster_done && (r_state == S_RENDER);
    w_promote_done  = w_done && ((VSYNC_LOCKED == 0) || i_vblank_start);
    w_promote_ready = (VSYNC_LOCKED != 0) && i_vblank_start && !w_done && w_ready_found;
    w_drop          = w_done && w_ready_found;
    w_new_frame     = w_promote_done || w_promote_ready;
    w_disp_nxt      = w_promote_done ? r_target : w_promote_ready ? w_ready_idx : r_disp;
    w_roles_upd     = r_roles;
    if (w_drop) w_roles_upd[w_ready_idx] = ROLE_FREE;
    if (w_new_frame) begin
      w_roles_upd[r_disp]     = ROLE_FREE;
      w_roles_upd[w_disp_nxt] = ROLE_DISPLAY;
    end else if (w_done) w_roles_upd[r_target] = ROLE_READY;
  end

  gfg_free_buffer_picker #(
    .N     (NUM_BUFFERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_roles (w_roles_upd),
    .o_found (w_free_found),
    .o_idx   (w_free_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    unique case (r_state)
      S_IDLE: if (i_raster_start_req) begin
        w_grant = w_free_found;
        if (w_free_found) w_state_nxt = S_RENDER;
        else w_state_nxt = S_WAIT_FREE;
      end
      S_WAIT_FREE: begin
        w_grant = w_free_found;
        if (w_free_found) w_state_nxt = S_RENDER;
      end
      S_RENDER: if (w_done) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    w_roles_nxt = w_roles_upd;
    if (w_grant) w_roles_nxt[w_free_idx] = ROLE_RENDER;
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_roles     <= (2 * NUM_BUFFERS)'(ROLE_DISPLAY);
      r_state     <= S_IDLE;
      r_target    <= '0;
      r_disp      <= '0;
      r_grant     <= 1'b0;
      r_new_frame <= 1'b0;
      r_err       <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_roles     <= w_roles_nxt;
      r_state     <= w_state_nxt;
      if (w_grant) r_target <= w_free_idx;
      r_disp      <= w_disp_nxt;
      r_grant     <= w_grant;
      r_new_frame <= w_new_frame;
      r_err       <= r_err | (i_raster_done && (r_state != S_RENDER));
      if (w_drop && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign o_raster_grant       = r_grant;
  assign o_raster_target      = r_target;
  assign o_raster_in_progress = (r_state == S_RENDER);
  assign o_display_source     = r_disp;
  assign o_new_frame          = r_new_frame;
  assign o_ready_pending      = w_ready_found;
  assign o_dropped_frames     = r_drop_cnt;
  assign o_protocol_err       = r_err;
endmodule

// File: tb/tb_gfg_frame_buffer_swap_ctrl.sv
// tb_gfg_frame_buffer_swap_ctrl: directed vectors for 3-buffer vsync-locked, 2-buffer and free-running builds
module tb_gfg_frame_buffer_swap_ctrl;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic vb3 = 0, rq3 = 0, dn3 = 0, vb2 = 0, rq2 = 0, dn2 = 0, vb0 = 0, rq0 = 0, dn0 = 0;
  logic g3, ip3, nf3, rp3, e3, g2, ip2, nf2, rp2, e2, g0, ip0, nf0, rp0, e0;
  logic [1:0] t3, d3, t0, d0;
  logic t2, d2;
  logic [15:0] dr3, dr2, dr0;
  int checks = 0, errors = 0;

  gfg_frame_buffer_swap_ctrl #(.NUM_BUFFERS(3), .VSYNC_LOCKED(1), .DROP_CNT_W(16)) u3 (
    .i_clk(clk), .i_arst_n(arst_n), .i_vblank_start(vb3), .i_raster_start_req(rq3),
    .i_raster_done(dn3), .o_raster_grant(g3), .o_raster_target(t3), .o_raster_in_progress(ip3),
    .o_display_source(d3), .o_new_frame(nf3), .o_ready_pending(rp3), .o_dropped_frames(dr3),
    .o_protocol_err(e3));
  gfg_frame_buffer_swap_ctrl #(.NUM_BUFFERS(2), .VSYNC_LOCKED(1), .DROP_CNT_W(16)) u2 (
    .i_clk(clk), .i_arst_n(arst_n), .i_vblank_start(vb2), .i_raster_start_req(rq2),
    .i_raster_done(dn2), .o_raster_grant(g2), .o_raster_target(t2), .o_raster_in_progress(ip2),
    .o_display_source(d2), .o_new_frame(nf2), .o_ready_pending(rp2), .o_dropped_frames(dr2),
    .o_protocol_err(e2));
  gfg_frame_buffer_swap_ctrl #(.NUM_BUFFERS(3), .VSYNC_LOCKED(0), .DROP_CNT_W(16)) u0 (
    .i_clk(clk), .i_arst_n(arst_n), .i_vblank_start(vb0), .i_raster_start_req(rq0),
    .i_raster_done(dn0), .o_raster_grant(g0), .o_raster_target(t0), .o_raster_in_progress(ip0),
    .o_display_source(d0), .o_new_frame(nf0), .o_ready_pending(rp0), .o_dropped_frames(dr0),
    .o_protocol_err(e0));

  typedef struct {
    logic vb, rq, dn;
    integer g, t, ip, d, nf, rp, dr, e;
  } vec_t;
  vec_t vecs[21];

  function automatic vec_t mv(input integer vb, rq, dn, g, t, ip, d, nf, rp, dr, e);
    vec_t v;
    v.vb = vb[0]; v.rq = rq[0]; v.dn = dn[0];
    v.g = g; v.t = t; v.ip = ip; v.d = d; v.nf = nf; v.rp = rp; v.dr = dr; v.e = e;
    return v;
  endfunction

  // {grant, target, in_progress, display, new_frame, ready_pending, dropped, err}
  function automatic logic [31:0] pk(input integer g, t, ip, d, nf, rp, dr, e);
    return {7'b0, g[0], t[1:0], ip[0], d[1:0], nf[0], rp[0], dr[15:0], e[0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             vb rq dn  g  t ip  d nf rp dr  e
    vecs[0]  = mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mv(0, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mv(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[3]  = mv(0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);
    vecs[4]  = mv(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
    vecs[5]  = mv(1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0);
    vecs[6]  = mv(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    vecs[7]  = mv(0, 1, 0, 1, 0, 1, 1, 0, 0, 0, 0);
    vecs[8]  = mv(0, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0);
    vecs[9]  = mv(0, 1, 0, 1, 2, 1, 1, 0, 1, 0, 0);
    vecs[10] = mv(0, 0, 1, 0, 2, 0, 1, 0, 1, 1, 0);
    vecs[11] = mv(0, 1, 0, 1, 0, 1, 1, 0, 1, 1, 0);
    vecs[12] = mv(1, 0, 0, 0, 0, 1, 2, 1, 0, 1, 0);
    vecs[13] = mv(1, 0, 1, 0, 0, 0, 0, 1, 0, 1, 0);
    vecs[14] = mv(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[15] = mv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    vecs[16] = mv(0, 1, 0, 1, 1, 1, 0, 0, 0, 1, 1);
    vecs[17] = mv(0, 0, 1, 0, 1, 0, 0, 0, 1, 1, 1);
    vecs[18] = mv(0, 1, 0, 1, 2, 1, 0, 0, 1, 1, 1);
    vecs[19] = mv(1, 0, 1, 0, 2, 0, 2, 1, 0, 2, 1);
    vecs[20] = mv(0, 1, 0, 1, 0, 1, 2, 0, 0, 2, 1);

    #1;
    check("reset_n3", pk(g3, t3, ip3, d3, nf3, rp3, dr3, e3), 32'd0);
    check("reset_n2", pk(g2, t2, ip2, d2, nf2, rp2, dr2, e2), 32'd0);
    check("reset_vl0", pk(g0, t0, ip0, d0, nf0, rp0, dr0, e0), 32'd0);
    repeat (3) @(negedge clk);
    arst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      vb3 = vecs[i].vb; rq3 = vecs[i].rq; dn3 = vecs[i].dn;
      tick();
      check($sformatf("vec%0d", i), pk(g3, t3, ip3, d3, nf3, rp3, dr3, e3),
            pk(vecs[i].g, vecs[i].t, vecs[i].ip, vecs[i].d, vecs[i].nf, vecs[i].rp, vecs[i].dr, vecs[i].e));
    end

    // asynchronous reset while u3 is rendering, checked before any clock edge
    @(negedge clk);
    vb3 = 0; rq3 = 0; dn3 = 0;
    #2 arst_n = 1'b0;
    #1 check("async_reset_mid_render", pk(g3, t3, ip3, d3, nf3, rp3, dr3, e3), 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
    tick();
    check("post_reset_idle", pk(g3, t3, ip3, d3, nf3, rp3, dr3, e3), 32'd0);
    @(negedge clk);
    rq3 = 1;
    tick();
    check("post_reset_grant", pk(g3, t3, ip3, d3, nf3, rp3, dr3, e3), pk(1, 1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    rq3 = 0;

    // two buffers: requester must wait for vblank to free the old display
    rq2 = 1;
    tick();
    check("n2_grant", pk(g2, t2, ip2, d2, nf2, rp2, dr2, e2), pk(1, 1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    rq2 = 0; dn2 = 1;
    tick();
    check("n2_done", pk(g2, t2, ip2, d2, nf2, rp2, dr2, e2), pk(0, 1, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    dn2 = 0; rq2 = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("n2_wait%0d", i), pk(g2, t2, ip2, d2, nf2, rp2, dr2, e2), pk(0, 1, 0, 0, 0, 1, 0, 0));
    end
    @(negedge clk);
    vb2 = 1;
    tick();
    check("n2_vblank_grant", pk(g2, t2, ip2, d2, nf2, rp2, dr2, e2), pk(1, 0, 1, 1, 1, 0, 0, 0));
    @(negedge clk);
    vb2 = 0; rq2 = 0;
    tick();
    check("n2_render", pk(g2, t2, ip2, d2, nf2, rp2, dr2, e2), pk(0, 0, 1, 1, 0, 0, 0, 0));

    // free-running build: done swaps the display directly, vblank ignored
    @(negedge clk);
    rq0 = 1;
    tick();
    check("vl0_grant", pk(g0, t0, ip0, d0, nf0, rp0, dr0, e0), pk(1, 1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    rq0 = 0; dn0 = 1;
    tick();
    check("vl0_done_swap", pk(g0, t0, ip0, d0, nf0, rp0, dr0, e0), pk(0, 1, 0, 1, 1, 0, 0, 0));
    @(negedge clk);
    dn0 = 0; vb0 = 1;
    tick();
    check("vl0_vblank_ignored", pk(g0, t0, ip0, d0, nf0, rp0, dr0, e0), pk(0, 1, 0, 1, 0, 0, 0, 0));
    @(negedge clk);
    vb0 = 0; rq0 = 1;
    tick();
    check("vl0_grant2", pk(g0, t0, ip0, d0, nf0, rp0, dr0, e0), pk(1, 0, 1, 1, 0, 0, 0, 0));
    @(negedge clk);
    rq0 = 0; dn0 = 1;
    tick();
    check("vl0_done_swap2", pk(g0, t0, ip0, d0, nf0, rp0, dr0, e0), pk(0, 0, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    dn0 = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gfg_frame_buffer_swap_ctrl.md
Name: gfg_frame_buffer_swap_ctrl

Overview:
- Generalised frame-buffer ownership/swap controller for the gfg pipeline, replacing the fixed double-buffer swapping controller.
- Manages NUM_BUFFERS buffers, each holding one role: FREE, RENDER, READY or DISPLAY.
- Hands render targets to the rasterizer through a request/grant handshake and promotes finished frames to the VGA read side.
- Promotion happens at vblank or immediately, selected by mode.
- Sits in the i_clk domain between the rasterizer and gfg_frame_buffers_datapath.

Parameters:
- NUM_BUFFERS, 3, number of frame buffers; legal 2..4.
- VSYNC_LOCKED, 1, 1 = promote READY to DISPLAY only on i_vblank_start; 0 = promote on completion (tearing permitted).
- DROP_CNT_W, 16, width of the dropped-frame counter.
- IDX_W, derived, max(1, clog2(NUM_BUFFERS)), buffer index width.

Ports:
- i_clk  in  1  system clock.
- i_arst_n  in  1  asynchronous active-low reset.
- i_vblank_start  in  1  single-cycle pulse, already synchronised to i_clk.
- i_raster_start_req  in  1  rasterizer requests a buffer; level, held until granted.
- i_raster_done  in  1  single-cycle pulse; current render buffer complete.
- o_raster_grant  out  1  single-cycle pulse; o_raster_target is valid from this cycle.
- o_raster_target  out  IDX_W  buffer index the rasterizer writes.
- o_raster_in_progress  out  1  high while the FSM is in S_RENDER.
- o_display_source  out  IDX_W  buffer index the VGA side reads.
- o_new_frame  out  1  single-cycle pulse when o_display_source changes.
- o_ready_pending  out  1  a READY buffer exists.
- o_dropped_frames  out  DROP_CNT_W  saturating count of overwritten READY frames.
- o_protocol_err  out  1  sticky; i_raster_done seen outside S_RENDER.

Behaviour:
- Reset (async assert, synchronous release to i_clk edge):
  - Buffer 0 = DISPLAY; all others FREE.
  - FSM = S_IDLE.
  - All outputs 0, o_display_source = 0, o_raster_target = 0.
- Role table: one 2-bit register per buffer.
  - Invariant: exactly one DISPLAY; at most one RENDER; at most one READY.
- Rasterizer FSM, states S_IDLE, S_RENDER, S_WAIT_FREE:
  - S_IDLE, req=1, a FREE buffer exists:
    - Lowest-index FREE buffer becomes RENDER; o_raster_target = that index.
    - o_raster_grant = 1 for one cycle; go to S_RENDER.
    - Latency: req sampled at edge k gives grant/target registered at edge k+1.
  - S_IDLE, req=1, no FREE buffer: go to S_WAIT_FREE; no grant.
  - S_WAIT_FREE: grant as soon as a buffer becomes FREE, evaluated after the same-cycle display update. Then go to S_RENDER.
  - S_RENDER, done=1:
    - RENDER buffer becomes READY; go to S_IDLE.
    - If a READY buffer already existed, the old READY becomes FREE and o_dropped_frames increments. The counter saturates at all-ones.
  - Done outside S_RENDER: ignored, o_protocol_err set (cleared only by reset).
- o_raster_target holds its value after done until the next grant.
- Display promotion:
  - VSYNC_LOCKED=1: on i_vblank_start with a READY buffer present:
    - READY becomes DISPLAY; old DISPLAY becomes FREE.
    - o_display_source updates and o_new_frame pulses at the next edge.
  - Vblank with no READY buffer: no change, no pulse.
  - VSYNC_LOCKED=0: promotion happens on i_raster_done directly; that buffer becomes DISPLAY in one step; i_vblank_start is ignored.
- Simultaneous done and vblank (VSYNC_LOCKED=1): the just-completed buffer is promoted directly to DISPLAY.
  - Any older READY buffer becomes FREE and counts as a drop.
  - The old DISPLAY becomes FREE.
- NUM_BUFFERS=2: after done the rasterizer always waits in S_WAIT_FREE until vblank frees the old display buffer. Drops are impossible.
- Concurrent req with a freeing event uses the post-update role table. Ties go to the lowest index.
- Reset mid-frame: all roles return to reset state; any in-flight render is discarded without counting a drop.

Decomposition:
- Package/include gfg_fb_pkg:
  - Role encodings ROLE_FREE=0, ROLE_DISPLAY=1, ROLE_RENDER=2, ROLE_READY=3.
  - FSM state encodings.
  - The IDX_W derivation function.
- Sub-module gfg_free_buffer_picker: combinational lowest-index FREE finder over the role vector. Outputs found flag and index.

Test Plan:
- Reset, NUM_BUFFERS=3: hold req from cycle 5 -> grant pulse at cycle 6, o_raster_target=1, o_display_source=0, o_raster_in_progress=1.
- Done pulse, then vblank 10 cycles later -> o_ready_pending=1 until vblank; o_new_frame one cycle; o_display_source=1; buffer 0 FREE; next req granted target=0.
- NUM_BUFFERS=3: render two frames before any vblank -> second done drops the first; o_dropped_frames=1; vblank shows the second frame's index. Third req is granted immediately, not via S_WAIT_FREE.
- NUM_BUFFERS=2: done at cycle 20, req held, vblank at cycle 40 -> no grant before 40; grant at 41 with target=0; o_display_source=1.
- Done and vblank in the same cycle -> completed buffer displayed next edge, o_new_frame=1; VSYNC_LOCKED=0 build: display switches on done with vblank tied low.
- Done pulse while in S_IDLE -> o_protocol_err=1 and stays 1; assert i_arst_n low mid-render -> all outputs return to reset values asynchronously.
